// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch FSM; define FETCH_HALT_ON_ERROR_EN to halt on a decoder error at handshake
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        dec_error,
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic capture, handshake, halt_hit;
  assign handshake = state == HOLD && dec_ready;
`ifdef FETCH_HALT_ON_ERROR_EN
  assign halt_hit = handshake && dec_error;
  assign halted = state == HALT;
`else
  logic unused_dec_error;
  assign unused_dec_error = dec_error;
  assign halt_hit = 1'b0;
  assign halted = 1'b0;
`endif
  assign imem_req = state == REQ;
  assign imem_addr = fetch_pc;
  assign dec_valid = state == HOLD;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // state and fetch address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end
  // next state: halt beats redirect, redirect beats ack and decoder handshake
  always_comb begin
    state_nxt = state;
    fetch_pc_nxt = fetch_pc;
    capture = 1'b0;
    if (halt_hit) state_nxt = HALT;
    else if (state != HALT && redirect_valid) begin
      state_nxt = REQ;
      fetch_pc_nxt = {redirect_target[31:2], 2'b00};
    end else if (state == IDLE || handshake) state_nxt = REQ;
    else if (state == REQ && imem_ack) begin
      state_nxt = HOLD;
      fetch_pc_nxt = fetch_pc + 32'd4;
      capture = 1'b1;
    end
  end
  // held instruction and its address, loaded only on an accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc <= RESET_PC;
    end else if (capture) begin
      instr <= imem_rdata;
      pc <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus against a transaction-level model of the fetch stage
module tb_fetch_stage;
`ifdef FETCH_HALT_ON_ERROR_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, imem_ack, dec_ready, redirect_valid, dec_error;
  logic [31:0] imem_rdata, redirect_target;
  logic imem_req, dec_valid, halted;
  logic [31:0] imem_addr, instr, pc;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic w_rst_n, w_ack, w_ready;
  logic [31:0] w_rdata;
  logic w_req, w_dec_valid, w_halted;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3;
  int total = 0, bad = 0;
  bit m_idle, m_hold, m_halt;
  logic [31:0] m_fetch, m_instr, m_pc;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .instr(instr), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .pc(pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .dec_error(dec_error), .halted(halted)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .dec_valid(w_dec_valid),
    .dec_ready(w_ready), .instr(w_instr), .opcode(w_opcode), .funct3(w_funct3),
    .funct7(w_funct7), .pc(w_pc), .redirect_valid(1'b0),
    .redirect_target(32'h0), .dec_error(1'b0), .halted(w_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_hold = 0; m_halt = 0;
    m_fetch = 32'h0; m_instr = 32'h0; m_pc = 32'h0;
  endtask

  // one clock of the fetch rules, applied to the inputs presented this cycle
  task automatic model_step();
    if (m_halt) return;
    if (m_idle) begin
      m_idle = 0;
      if (redirect_valid) m_fetch = redirect_target & ~32'd3;
    end else if (m_hold) begin
      if (HALT_EN && dec_ready && dec_error) begin
        m_halt = 1; m_hold = 0;
      end else if (redirect_valid) begin
        m_fetch = redirect_target & ~32'd3; m_hold = 0;
      end else if (dec_ready) m_hold = 0;
    end else begin
      if (redirect_valid) m_fetch = redirect_target & ~32'd3;
      else if (imem_ack) begin
        m_instr = imem_rdata; m_pc = m_fetch; m_fetch = m_fetch + 32'd4; m_hold = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(!m_idle && !m_hold && !m_halt));
    chk("imem_addr", imem_addr, m_fetch);
    chk("dec_valid", 32'(dec_valid), 32'(m_hold));
    chk("instr", instr, m_instr);
    chk("pc", pc, m_pc);
    chk("opcode", 32'(opcode), 32'(m_instr[6:0]));
    chk("funct3", 32'(funct3), 32'(m_instr[14:12]));
    chk("funct7", 32'(funct7), 32'(m_instr[31:25]));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  task automatic quiet();
    imem_ack = 0; dec_ready = 0; redirect_valid = 0; dec_error = 0;
    imem_rdata = 32'h0; redirect_target = 32'h0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1;
  endtask

  initial begin
    quiet();
    w_rst_n = 0; w_ack = 0; w_ready = 0; w_rdata = 32'h0;
    do_reset();
    // straight-line fetch of three words
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      imem_ack = 1; imem_rdata = 32'h0050_0093; dec_ready = 1;
      tick();
      chk("seq_opcode", 32'(opcode), 32'h13);
      chk("seq_funct3", 32'(funct3), 32'h0);
      chk("seq_pc", pc, 32'(i * 4));
      imem_ack = 0;
      tick();
    end
    // decoder stall: held instruction must stay put
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; dec_ready = 0;
    tick();
    imem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(dec_valid), 32'h1);
      chk("stall_instr", instr, 32'hDEAD_BEEF);
    end
    // redirect while holding with decoder ready drops the instruction
    redirect_valid = 1; redirect_target = 32'h103; dec_ready = 1;
    tick();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_drop", 32'(dec_valid), 32'h0);
    // redirect racing an ack discards the returned data
    redirect_target = 32'h200; imem_ack = 1; imem_rdata = 32'h1234_5678;
    tick();
    chk("redir_ack_addr", imem_addr, 32'h200);
    chk("redir_ack_valid", 32'(dec_valid), 32'h0);
    quiet();
    // asynchronous reset mid-request, then a late ack while idle
    #2 rst_n = 0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1; imem_ack = 1;
    tick();
    chk("late_ack_addr", imem_addr, 32'h0);
    imem_ack = 0;
    // decoder error at handshake together with a redirect
    imem_ack = 1; imem_rdata = 32'h0000_0013;
    tick();
    quiet();
    dec_ready = 1; dec_error = 1; redirect_valid = 1; redirect_target = 32'h40;
    tick();
    chk("err_halted", 32'(halted), 32'(HALT_EN));
    quiet();
    tick();
    chk("err_req", 32'(imem_req), 32'(!HALT_EN));
    do_reset();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      imem_ack = ($urandom_range(1, 0) == 1);
      imem_rdata = $urandom;
      dec_ready = ($urandom_range(1, 0) == 1);
      dec_error = ($urandom_range(5, 0) == 0);
      redirect_valid = ($urandom_range(7, 0) == 0);
      redirect_target = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
      tick();
      if (m_halt || i % 97 == 96) do_reset();
    end
    // wraparound of the fetch address
    quiet();
    @(negedge clk);
    w_rst_n = 1;
    @(negedge clk);
    chk("wrap_req", 32'(w_req), 32'h1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_ack = 1; w_rdata = 32'h0000_0033;
    @(negedge clk);
    w_ack = 0;
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(w_dec_valid), 32'h1);
    w_ready = 1;
    @(negedge clk);
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_req1", 32'(w_req), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
